t03_game_mmio_writer: RTL and testbench

- CPU/game-logic side of the DPU MMIO link.
- Takes a snapshot of game state on a commit strobe and packs it into two 32-bit words: status and position.
- Issues them as sequential bus writes: status first, then position. Each write is held until the bus acknowledges it.
- The DPU-side register block decodes these writes by address alone, so addr must carry a DPU address only during an active write.

---
 rtl/t03_mmio_pkg.sv | 52 +++++
 rtl/t03_mmio_pack.sv | 31 +++
 rtl/t03_game_mmio_writer.sv | 159 +++++++++++++++
 tb/tb_t03_game_mmio_writer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_mmio_pkg.sv
// Shared definitions for the game-side DPU MMIO writer: bus addresses,
// writer state encoding, word layouts and the coordinate saturation helper.
package t03_mmio_pkg;

  // Default DPU register addresses; the idle address is never decoded by the DPU.
  localparam logic [31:0] T03_STATUS_ADDR = 32'hFF00_0004;
  localparam logic [31:0] T03_POS_ADDR    = 32'hFF00_0008;
  localparam logic [31:0] T03_IDLE_ADDR   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_STATUS = 2'd1,
    ST_WR_POS    = 2'd2,
    ST_DONE      = 2'd3
  } wr_state_e;

  // Status word layout (LSB positions); unlisted bits are zero.
  localparam int unsigned ST_GAME_LSB     = 28;  // [30:28]
  localparam int unsigned ST_P1STATE_LSB  = 26;  // [27:26]
  localparam int unsigned ST_P2STATE_LSB  = 24;  // [25:24]
  localparam int unsigned ST_P1HEALTH_LSB = 20;  // [23:20]
  localparam int unsigned ST_P2HEALTH_LSB = 16;  // [19:16]
  localparam int unsigned ST_P1LEFT_BIT   = 1;
  localparam int unsigned ST_P2LEFT_BIT   = 0;

  // Position word layout: one saturated byte per coordinate.
  localparam int unsigned POS_X1_LSB = 24;
  localparam int unsigned POS_Y1_LSB = 16;
  localparam int unsigned POS_X2_LSB = 8;
  localparam int unsigned POS_Y2_LSB = 0;

  // One frozen copy of everything that gets published.
  typedef struct packed {
    logic [2:0]  game_state;
    logic [1:0]  p1_state;
    logic [1:0]  p2_state;
    logic [3:0]  p1_health;
    logic [3:0]  p2_health;
    logic        p1_left;
    logic        p2_left;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
  } snapshot_t;

  // Clamp an 11-bit screen coordinate into one byte.
  function automatic logic [7:0] sat8(input logic [10:0] v);
    return (v > 11'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/t03_mmio_pack.sv
// Combinational packing of a game-state snapshot into the status and
// position bus words. Also usable as a reference model on the DPU side.
module t03_mmio_pack
  import t03_mmio_pkg::*;
(
  input  snapshot_t   snap,
  output logic [31:0] status_word,
  output logic [31:0] pos_word
);

  // Place each field at its fixed bit position; coordinates saturate to a byte.
  always_comb begin
    // NOTE: every output gets a full default first so no path leaves it unassigned (no latch).
    status_word = '0;
    pos_word    = '0;

    status_word[ST_GAME_LSB     +: 3] = snap.game_state;
    status_word[ST_P1STATE_LSB  +: 2] = snap.p1_state;
    status_word[ST_P2STATE_LSB  +: 2] = snap.p2_state;
    status_word[ST_P1HEALTH_LSB +: 4] = snap.p1_health;
    status_word[ST_P2HEALTH_LSB +: 4] = snap.p2_health;
    status_word[ST_P1LEFT_BIT]        = snap.p1_left;
    status_word[ST_P2LEFT_BIT]        = snap.p2_left;

    pos_word[POS_X1_LSB +: 8] = sat8(snap.x1);
    pos_word[POS_Y1_LSB +: 8] = sat8(snap.y1);
    pos_word[POS_X2_LSB +: 8] = sat8(snap.x2);
    pos_word[POS_Y2_LSB +: 8] = sat8(snap.y2);
  end

endmodule

// File: rtl/t03_game_mmio_writer.sv
// Game-side MMIO writer: snapshots game state on commit and publishes it to
// the DPU as two held bus writes (status, then position), then pulses done.
// Commits arriving mid-transaction collapse into one follow-up request.
// Optional: define T03_MMIO_DIFF_EN to skip words equal to the last acked copy.
module t03_game_mmio_writer
  import t03_mmio_pkg::*;
#(
  parameter logic [31:0] STATUS_ADDR = T03_STATUS_ADDR,
  parameter logic [31:0] POS_ADDR    = T03_POS_ADDR,
  parameter logic [31:0] IDLE_ADDR   = T03_IDLE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [2:0]  gameState,
  input  logic [1:0]  p1State,
  input  logic [1:0]  p2State,
  input  logic [3:0]  p1health,
  input  logic [3:0]  p2health,
  input  logic        p1Left,
  input  logic        p2Left,
  input  logic [10:0] x1,
  input  logic [10:0] y1,
  input  logic [10:0] x2,
  input  logic [10:0] y2,
  input  logic        bus_ack,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done
);

  wr_state_e   state_q, state_d;
  logic        pending_q, pending_d;
  logic        capture;
  snapshot_t   live_snap, snap_q, snap_d;
  logic [31:0] status_w, pos_w;
  logic [31:0] addr_d, data_d;
  logic        wen_d, busy_d, done_d;
  logic        status_same, pos_same;

  assign live_snap = '{game_state: gameState, p1_state: p1State, p2_state: p2State,
                       p1_health: p1health, p2_health: p2health,
                       p1_left: p1Left, p2_left: p2Left,
                       x1: x1, y1: y1, x2: x2, y2: y2};

  // A new snapshot is taken from IDLE on commit, or straight out of DONE when
  // a request is waiting (queued earlier or arriving in that very cycle).
  assign capture = ((state_q == ST_IDLE) && commit) ||
                   ((state_q == ST_DONE) && (pending_q || commit));

  // Pack what the snapshot will hold after this edge, so the registered bus
  // outputs can carry the new words in the same cycle the state advances.
  assign snap_d = capture ? live_snap : snap_q;

  t03_mmio_pack u_pack (
    .snap        (snap_d),
    .status_word (status_w),
    .pos_word    (pos_w)
  );

`ifdef T03_MMIO_DIFF_EN
  logic [31:0] shadow_status_q, shadow_pos_q;

  assign status_same = (status_w == shadow_status_q);
  assign pos_same    = (pos_w    == shadow_pos_q);

  // Remember the last word the DPU actually accepted at each address.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_status_q <= '0;
      shadow_pos_q    <= '0;
    end else begin
      if ((state_q == ST_WR_STATUS) && bus_ack) shadow_status_q <= data;
      if ((state_q == ST_WR_POS)    && bus_ack) shadow_pos_q    <= data;
    end
  end
`else
  // Without change detection every word is always written.
  assign status_same = 1'b0;
  assign pos_same    = 1'b0;
`endif

  // Next state, pending request and the output values for the next state.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;

    case (state_q)
      ST_WR_STATUS: begin
        if (commit)  pending_d = 1'b1;
        if (bus_ack) state_d   = pos_same ? ST_DONE : ST_WR_POS;
      end
      ST_WR_POS: begin
        if (commit)  pending_d = 1'b1;
        if (bus_ack) state_d   = ST_DONE;
      end
      ST_DONE: begin
        pending_d = 1'b0;
        if (!capture) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (!status_same)   state_d = ST_WR_STATUS;
      else if (!pos_same) state_d = ST_WR_POS;
      else                state_d = ST_DONE;
    end

    addr_d = IDLE_ADDR;
    data_d = '0;
    wen_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_WR_STATUS: begin
        addr_d = STATUS_ADDR;
        data_d = status_w;
        wen_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_WR_POS: begin
        addr_d = POS_ADDR;
        data_d = pos_w;
        wen_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State, snapshot and registered bus outputs; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      snap_q    <= '0;
      addr      <= IDLE_ADDR;
      data      <= '0;
      wen       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      addr      <= addr_d;
      data      <= data_d;
      wen       <= wen_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_t03_game_mmio_writer.sv
// Self-checking bench for t03_game_mmio_writer. Expected bus writes are
// queued when a commit is driven and compared as the DUT's writes are acked.
// Sections for T03_MMIO_DIFF_EN follow the same macro as the RTL.
module tb_t03_game_mmio_writer;
  import t03_mmio_pkg::*;

  localparam logic [31:0] SA = 32'hFF00_0004;
  localparam logic [31:0] PA = 32'hFF00_0008;
  localparam logic [31:0] IA = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit = 1'b0;
  logic [2:0]  gs = '0;
  logic [1:0]  p1s = '0, p2s = '0;
  logic [3:0]  p1h = '0, p2h = '0;
  logic        p1l = 1'b0, p2l = 1'b0;
  logic [10:0] cx1 = '0, cy1 = '0, cx2 = '0, cy2 = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] addr, data;
  logic        wen, busy, done;

  t03_game_mmio_writer dut (
    .clk(clk), .rst(rst), .commit(commit),
    .gameState(gs), .p1State(p1s), .p2State(p2s),
    .p1health(p1h), .p2health(p2h), .p1Left(p1l), .p2Left(p2l),
    .x1(cx1), .y1(cy1), .x2(cx2), .y2(cy2),
    .bus_ack(bus_ack), .addr(addr), .data(data), .wen(wen),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  gs;
    logic [1:0]  p1s, p2s;
    logic [3:0]  p1h, p2h;
    logic        p1l, p2l;
    logic [10:0] x1, y1, x2, y2;
    logic [31:0] exp_status, exp_pos;
    int          ack_dly;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[6];
  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   writes_acc = 0;
  int   done_cnt   = 0;
  int   ack_delay  = 0;  // -1: hold ack low, 0: ack always high, N: ack after N wait cycles
  bit   mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    gs = v.gs; p1s = v.p1s; p2s = v.p2s; p1h = v.p1h; p2h = v.p2h;
    p1l = v.p1l; p2l = v.p2l; cx1 = v.x1; cy1 = v.y1; cx2 = v.x2; cy2 = v.y2;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle commit; returns 1 time unit after the capture edge.
  task automatic start_commit(input vec_t v);
    @(posedge clk); #1;
    set_inputs(v);
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  // Count falling edges until done is seen; lat = -1 on timeout.
  task automatic wait_done(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles (t=%0t)", max_cycles, $time);
    end
  endtask

  // Bus slave: acknowledges each held write after ack_delay wait cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (ack_delay < 0) begin
        bus_ack = 1'b0;
        cnt = 0;
      end else if (ack_delay == 0) begin
        bus_ack = 1'b1;
        cnt = 0;
      end else if (wen === 1'b1) begin
        if (cnt == ack_delay) begin
          bus_ack = 1'b1;
          cnt = 0;
        end else begin
          bus_ack = 1'b0;
          cnt++;
        end
      end else begin
        bus_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: scoreboard on accepted writes, idle-bus, busy and hold checks.
  initial begin
    logic        prev_wait = 1'b0;
    logic        prev_rst  = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    wr_t         e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (wen === 1'b1 && bus_ack === 1'b1) begin
          writes_acc++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %h data %h, expected no write (t=%0t)", addr, data, $time);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", addr, e.a);
            check("wr_data", data, e.d);
          end
        end
        if (wen !== 1'b1) begin
          check("idle_addr", addr, IA);
          check("idle_data", data, 32'h0);
        end
        check("busy_eq_wen", {31'b0, busy}, {31'b0, wen});
        if (prev_wait && !prev_rst) begin
          check("hold_wen",  {31'b0, wen}, 32'h1);
          check("hold_addr", addr, prev_addr);
          check("hold_data", data, prev_data);
        end
        if (done === 1'b1) done_cnt++;
      end
      prev_wait = (wen === 1'b1) && (bus_ack !== 1'b1);
      prev_rst  = rst;
      prev_addr = addr;
      prev_data = data;
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat, w0, d0;
    vec_t va, vd;

    //          gs    p1s   p2s   p1h    p2h    p1l   p2l   x1       y1      x2       y2       status         pos          dly
    vecs[0] = '{3'd5, 2'd1, 2'd2, 4'd9,  4'd3,  1'b1, 1'b0, 11'd300, 11'd40, 11'd255, 11'd0,   32'h5693_0002, 32'hFF28_FF00, 0};
    vecs[1] = '{3'd0, 2'd0, 2'd0, 4'd0,  4'd0,  1'b0, 1'b0, 11'd0,   11'd0,  11'd0,   11'd0,   32'h0000_0000, 32'h0000_0000, 2};
    vecs[2] = '{3'd7, 2'd3, 2'd3, 4'd15, 4'd15, 1'b1, 1'b1, 11'd2047,11'd2047,11'd2047,11'd2047,32'h7FFF_0003, 32'hFFFF_FFFF, 0};
    vecs[3] = '{3'd2, 2'd0, 2'd3, 4'd10, 4'd5,  1'b0, 1'b1, 11'd256, 11'd255,11'd1,   11'd1024,32'h23A5_0001, 32'hFFFF_01FF, 1};
    vecs[4] = '{3'd1, 2'd2, 2'd0, 4'd1,  4'd8,  1'b0, 1'b0, 11'd128, 11'd0,  11'd0,   11'd255, 32'h1818_0000, 32'h8000_00FF, 0};
    vecs[5] = '{3'd5, 2'd1, 2'd2, 4'd9,  4'd3,  1'b1, 1'b0, 11'd300, 11'd40, 11'd255, 11'd0,   32'h5693_0002, 32'hFF28_FF00, 3};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", addr, IA);
    check("rst_data", data, 32'h0);
    check("rst_wen",  {31'b0, wen},  32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Table-driven transactions with various ack delays.
    for (int i = 0; i < 6; i++) begin
      ack_delay = vecs[i].ack_dly;
      push_exp(SA, vecs[i].exp_status);
      push_exp(PA, vecs[i].exp_pos);
      start_commit(vecs[i]);
      wait_done(80, lat);
      check($sformatf("done_latency_v%0d", i), lat, 3 + 2 * vecs[i].ack_dly);
      check($sformatf("queue_empty_v%0d", i), exp_q.size(), 0);
    end

    // Two commits while in WR_STATUS: one follow-up with values live at DONE.
    ack_delay = 3;
    w0 = writes_acc;
    d0 = done_cnt;
    va = vecs[2];
    vd = vecs[0];
    push_exp(SA, va.exp_status);
    push_exp(PA, va.exp_pos);
    start_commit(va);
    set_inputs(vecs[3]);
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    @(posedge clk); #1;
    set_inputs(vecs[4]);
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    set_inputs(vd);
    push_exp(SA, vd.exp_status);
    push_exp(PA, vd.exp_pos);
    wait_done(80, lat);
    wait_done(80, lat);
    repeat (12) @(posedge clk);
    #1;
    check("pend_writes", writes_acc - w0, 4);
    check("pend_dones",  done_cnt - d0, 2);
    check("pend_queue",  exp_q.size(), 0);

    // Reset while waiting for ack in WR_POS, with a pending commit.
    ack_delay = 0;
    w0 = writes_acc;
    push_exp(SA, vecs[2].exp_status);
    start_commit(vecs[2]);
    @(posedge clk); #1;
    ack_delay = -1;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    check("pre_rst_wen",  {31'b0, wen}, 32'h1);
    check("pre_rst_addr", addr, PA);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_wen",  {31'b0, wen},  32'h0);
    check("post_rst_addr", addr, IA);
    check("post_rst_busy", {31'b0, busy}, 32'h0);
    check("post_rst_done", {31'b0, done}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_done",   done_cnt - d0, 0);
    check("rst_writes",    writes_acc - w0, 1);

    // After reset, a single commit yields exactly one transaction.
    ack_delay = 0;
    w0 = writes_acc;
    d0 = done_cnt;
    push_exp(SA, vecs[3].exp_status);
    push_exp(PA, vecs[3].exp_pos);
    start_commit(vecs[3]);
    wait_done(40, lat);
    check("post_rst_latency", lat, 3);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_writes", writes_acc - w0, 2);
    check("post_rst_dones",  done_cnt - d0, 1);

`ifdef T03_MMIO_DIFF_EN
    // Identical commit: done pulses without any bus write.
    w0 = writes_acc;
    start_commit(vecs[3]);
    wait_done(40, lat);
    check("diff_same_latency", lat, 1);
    repeat (5) @(posedge clk);
    #1;
    check("diff_same_writes", writes_acc - w0, 0);

    // Only p2health changes: only the status word is written.
    w0 = writes_acc;
    va = vecs[3];
    va.p2h = 4'd6;
    push_exp(SA, 32'h23A6_0001);
    start_commit(va);
    wait_done(40, lat);
    check("diff_status_latency", lat, 2);
    repeat (5) @(posedge clk);
    #1;
    check("diff_status_writes", writes_acc - w0, 1);
`else
    // Identical commit still writes both words.
    w0 = writes_acc;
    push_exp(SA, vecs[3].exp_status);
    push_exp(PA, vecs[3].exp_pos);
    start_commit(vecs[3]);
    wait_done(40, lat);
    check("repeat_latency", lat, 3);
    repeat (5) @(posedge clk);
    #1;
    check("repeat_writes", writes_acc - w0, 2);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
